// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer controller: FSM state
// encoding and width helpers used to size ports and the accumulator.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_e;

    // Accumulator width that can hold in_len full-scale unsigned products
    // without overflow.
    function automatic int fc_acc_width(input int data_width, input int in_len);
        return 2 * data_width + $clog2(in_len);
    endfunction

    // Index width that never collapses to zero bits for a length of one.
    function automatic int fc_idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/multiply_unit_fc.sv
// Unsigned DATA_WIDTH x DATA_WIDTH multiplier producing the full-width
// product; the controller owns exactly one of these.
module multiply_unit_fc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] product
);

    // Operands are widened first so the product keeps every bit.
    always_comb begin
        product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer controller: streams the input vector and each
// neuron's weight row out of two synchronous memories, accumulates the dot
// product through a single shared multiplier and hands each neuron result
// downstream over a valid/ready port.
module fc_layer_ctrl
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_LEN     = 16,
    parameter int OUT_LEN    = 8,
    parameter int ACC_WIDTH  = fc_acc_width(DATA_WIDTH, IN_LEN)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [fc_idx_width(IN_LEN)-1:0]           x_addr,
    input  logic [DATA_WIDTH-1:0]                     x_data,
    output logic [fc_idx_width(IN_LEN*OUT_LEN)-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]                     w_data,
    output logic                                      rd_en,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ACC_WIDTH-1:0]                      out_data,
    output logic [fc_idx_width(OUT_LEN)-1:0]          out_idx
);

    localparam int XW = fc_idx_width(IN_LEN);
    localparam int WW = fc_idx_width(IN_LEN * OUT_LEN);
    localparam int JW = fc_idx_width(OUT_LEN);

    localparam logic [XW-1:0] I_LAST = XW'(IN_LEN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OUT_LEN - 1);

    fc_state_e               state;
    logic [XW-1:0]           i;
    logic [JW-1:0]           j;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    mac_en;
    logic [2*DATA_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]    product_ext;

    multiply_unit_fc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .a       (x_data),
        .b       (w_data),
        .product (product)
    );

    assign x_addr  = i;
    assign out_idx = j;

    // Zero-extend the product to accumulator width before adding.
    always_comb begin
        product_ext = ACC_WIDTH'(product);
    end

    // Layer sequencer. Memory data arrives one cycle after each read strobe,
    // so mac_en is rd_en delayed by one cycle and marks when x_data/w_data
    // are valid to accumulate. Because weights are row-major, the next
    // neuron's first weight sits right after the previous neuron's last one,
    // so w_addr simply keeps counting across neurons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            acc       <= '0;
            mac_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            w_addr    <= '0;
        end else begin
            mac_en <= rd_en;
            if (mac_en) begin
                acc <= acc + product_ext;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        rd_en  <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        w_addr <= '0;
                        acc    <= '0;
                    end
                end

                ST_RUN: begin
                    if (i == I_LAST) begin
                        state <= ST_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        i      <= i + XW'(1);
                        w_addr <= w_addr + WW'(1);
                    end
                end

                ST_DRAIN: begin
                    state     <= ST_OUT;
                    out_valid <= 1'b1;
                    out_data  <= acc + product_ext;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j != J_LAST) begin
                            state  <= ST_RUN;
                            rd_en  <= 1'b1;
                            j      <= j + JW'(1);
                            i      <= '0;
                            w_addr <= w_addr + WW'(1);
                            acc    <= '0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl with IN_LEN=4, OUT_LEN=2,
// DATA_WIDTH=8. Expected neuron results are queued when a pass is launched
// and a monitor pops them on every output handshake.
module tb_fc_layer_ctrl;

    localparam int DW = 8;
    localparam int IL = 4;
    localparam int OL = 2;
    localparam int AW = 18;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    x_addr;
    logic [DW-1:0] x_data;
    logic [2:0]    w_addr;
    logic [DW-1:0] w_data;
    logic          rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic [0:0]    out_idx;

    logic [DW-1:0] xmem [IL];
    logic [DW-1:0] wmem [IL*OL];

    int nCompared;
    int nMismatched;
    int doneCount;
    int cycleCount;
    int runEntry;
    int doneBefore;
    logic rdPrev;
    logic validPrev;

    int expIdx[$];
    int expData[$];
    int traceX[$];
    int traceW[$];

    fc_layer_ctrl #(
        .DATA_WIDTH (DW),
        .IN_LEN     (IL),
        .OUT_LEN    (OL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xmem[x_addr];
            w_data <= wmem[w_addr];
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Loads both memories (byte k of each packed word is element k), queues
    // the two hand-computed neuron results and pulses start for one edge.
    task automatic applyStimulus(input logic [31:0] xPacked, input logic [63:0] wPacked,
                                 input int exp0, input int exp1);
        for (int k = 0; k < IL; k++) xmem[k] = xPacked[8*k +: 8];
        for (int k = 0; k < IL*OL; k++) wmem[k] = wPacked[8*k +: 8];
        expIdx.push_back(0);
        expData.push_back(exp0);
        expIdx.push_back(1);
        expData.push_back(exp1);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((busy || expData.size() != 0) && n < maxCycles) begin
            nextCycle();
            n++;
        end
        if (n >= maxCycles) begin
            checkOutput("timeout_busy", busy, 0);
            checkOutput("timeout_pending", expData.size(), 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_idx"}, out_idx, 0);
        checkOutput({tag, "_x_addr"}, x_addr, 0);
        checkOutput({tag, "_w_addr"}, w_addr, 0);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks per-neuron
    // latency from the first read strobe, counts done pulses, logs addresses.
    always @(negedge clk) begin
        int ei;
        int ed;
        cycleCount++;
        if (rst_n) begin
            if (rd_en && !rdPrev) runEntry = cycleCount;
            if (out_valid && !validPrev) checkOutput("latency", cycleCount - runEntry, IL + 1);
            if (out_valid && out_ready) begin
                if (expData.size() == 0) begin
                    checkOutput("unexpected_out", expData.size(), 1);
                end else begin
                    ei = expIdx.pop_front();
                    ed = expData.pop_front();
                    checkOutput("out_idx", out_idx, ei);
                    checkOutput("out_data", out_data, ed);
                end
            end
            if (done) doneCount++;
            if (rd_en) begin
                traceX.push_back(int'(x_addr));
                traceW.push_back(int'(w_addr));
            end
        end
        rdPrev    = rd_en;
        validPrev = out_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        doneCount   = 0;
        cycleCount  = 0;
        runEntry    = 0;
        rdPrev      = 1'b0;
        validPrev   = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        for (int k = 0; k < IL; k++) xmem[k] = '0;
        for (int k = 0; k < IL*OL; k++) wmem[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        nextCycle();

        // Basic pass with address trace: results 10 and 8.
        $display("[TB] basic pass");
        traceX.delete();
        traceW.delete();
        doneBefore = doneCount;
        applyStimulus(32'h04030201, 64'h00020002_01010101, 10, 8);
        waitIdle(200);
        checkOutput("done_basic", doneCount - doneBefore, 1);
        checkOutput("trace_len", traceW.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < traceW.size()) begin
                checkOutput("trace_w", traceW[k], k);
                checkOutput("trace_x", traceX[k], k % IL);
            end
        end

        // Full-scale operands: 4 * 255 * 255 = 260100 per neuron.
        $display("[TB] full-scale pass");
        doneBefore = doneCount;
        applyStimulus(32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 260100, 260100);
        waitIdle(200);
        checkOutput("done_full", doneCount - doneBefore, 1);

        // Backpressure on neuron 0 for 7 cycles: results 20 and 30.
        $display("[TB] backpressure pass");
        doneBefore = doneCount;
        out_ready  = 1'b0;
        applyStimulus(32'h04030201, 64'h04030201_01020304, 20, 30);
        for (int n = 0; n < 50 && !out_valid; n++) nextCycle();
        checkOutput("stall_valid_seen", out_valid, 1);
        for (int n = 0; n < 7; n++) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, 20);
            checkOutput("stall_idx", out_idx, 0);
            checkOutput("stall_rd_en", rd_en, 0);
            nextCycle();
        end
        out_ready = 1'b1;
        nextCycle();
        checkOutput("resume_rd_en", rd_en, 1);
        checkOutput("resume_w_addr", w_addr, 4);
        checkOutput("resume_x_addr", x_addr, 0);
        checkOutput("resume_valid", out_valid, 0);
        waitIdle(200);
        checkOutput("done_stall", doneCount - doneBefore, 1);

        // Start pulsed during RUN and in the DONE cycle must be ignored.
        $display("[TB] ignored start pass");
        doneBefore = doneCount;
        traceW.delete();
        traceX.delete();
        applyStimulus(32'h04030201, 64'h00020002_01010101, 10, 8);
        nextCycle();
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        for (int n = 0; n < 100 && !done; n++) nextCycle();
        checkOutput("done_seen", done, 1);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput("idle_after_done_start", busy, 0);
        nextCycle();
        checkOutput("still_idle", busy, 0);
        waitIdle(200);
        checkOutput("done_ignored", doneCount - doneBefore, 1);
        checkOutput("single_pass_reads", traceW.size(), 8);

        // Reset in RUN cycle 2 abandons the pass; a new pass is clean.
        $display("[TB] reset mid-pass");
        for (int k = 0; k < IL; k++) xmem[k] = 8'd9;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        doneBefore = doneCount;
        applyStimulus(32'h04030201, 64'h00020002_01010101, 10, 8);
        checkOutput("busy_after_release_start", busy, 1);
        waitIdle(200);
        checkOutput("done_after_reset", doneCount - doneBefore, 1);

        repeat (3) nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8, operand width (unsigned).
REQ-002 Parameter IN_LEN, 16, input-vector length (>=2).
REQ-003 Parameter OUT_LEN, 8, neuron count (>=1).
REQ-004 Parameter ACC_WIDTH, 2*DATA_WIDTH+$clog2(IN_LEN), accumulator/result width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  launch one full layer pass; sampled in IDLE only.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse after the last neuron is accepted.
REQ-010 x_addr  out  $clog2(IN_LEN)  input-vector read address.
REQ-011 x_data  in  DATA_WIDTH  input data; 1-cycle synchronous read latency.
REQ-012 w_addr  out  $clog2(IN_LEN*OUT_LEN)  weight read address.
REQ-013 w_data  in  DATA_WIDTH  weight data; 1-cycle synchronous read latency.
REQ-014 rd_en  out  1  read strobe for both memories.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  downstream accept.
REQ-017 out_data  out  ACC_WIDTH  neuron dot product.
REQ-018 out_idx  out  $clog2(OUT_LEN)  neuron index of out_data.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, OUT, DONE.
REQ-020 IDLE->RUN when start=1; clears accumulator, neuron j=0, element i=0.
REQ-021 RUN: rd_en=1, x_addr=i, w_addr=j*IN_LEN+i; i increments each cycle; RUN->DRAIN after i=IN_LEN-1 issued.
REQ-022 Each cycle following an rd_en cycle, acc += x_data*w_data through the shared multiplier, zero-extended to ACC_WIDTH; no overflow possible by width rule.
REQ-023 DRAIN: one cycle, rd_en=0, accumulates last product; DRAIN->OUT.
REQ-024 OUT: out_valid=1, out_data=acc, out_idx=j held stable until out_ready=1.
REQ-025 OUT with out_ready=1: if j<OUT_LEN-1 then j++, i=0, acc=0, ->RUN; else ->DONE.
REQ-026 out_valid SHALL NOT drop without out_ready; arbitrary backpressure stalls the FSM, no reads issued while stalled.
REQ-027 DONE: done=1 for exactly one cycle, ->IDLE.
REQ-028 start while busy is ignored; start in the DONE cycle is ignored.
REQ-029 Per-neuron latency from RUN entry to out_valid: IN_LEN+1 cycles.
REQ-030 rd_en=0 and addresses hold last value in IDLE, DRAIN, OUT, DONE.

Reset
REQ-031 rst_n low asynchronously forces IDLE, acc=0, i=0, j=0, busy=0, done=0, rd_en=0, out_valid=0, out_data=0, out_idx=0, x_addr=0, w_addr=0.
REQ-032 Reset mid-pass abandons the pass; no partial result or done emitted afterwards.
REQ-033 Reset release is taken synchronously to clk; first start accepted on the first edge after release.

Structure
REQ-034 Shared package fc_pkg holds the state encoding and the ACC_WIDTH derivation function.
REQ-035 One sub-module: multiply_unit_fc (DATA_WIDTH) instantiated once as the sole multiplier.
REQ-036 Weight memory layout is row-major: neuron j occupies addresses j*IN_LEN..j*IN_LEN+IN_LEN-1.

Verification (IN_LEN=4, OUT_LEN=2, DATA_WIDTH=8)
REQ-037 x={1,2,3,4}, w={1,1,1,1, 2,0,2,0}, out_ready=1 -> out (idx0,10), (idx1,8), then done pulse; out_valid 5 cycles after RUN entry.
REQ-038 All x=255, all w=255 -> out_data=260100 for both neurons, no truncation (ACC_WIDTH=18).
REQ-039 out_ready low 7 cycles on neuron 0 -> out_valid/out_data/out_idx stable, rd_en=0 throughout, neuron 1 starts the cycle after acceptance.
REQ-040 start pulsed during RUN and in the DONE cycle -> ignored; exactly one pass, one done.
REQ-041 rst_n asserted in RUN cycle 2 -> all outputs zero immediately; new start yields a clean correct pass.
REQ-042 Address trace check: w_addr sequence 0,1,2,3,4,5,6,7; x_addr 0..3 repeated.
